shift_right_iter: RTL and testbench



---
 rtl/shift_right_iter_pkg.sv | 26 ++
 rtl/shift_right_iter_step.sv | 13 +
 rtl/shift_right_iter.sv | 117 +++++++++++
 tb/tb_shift_right_iter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shift_right_iter_pkg.sv
// rtl/shift_right_iter_pkg.sv - shared Monociclo constants for the iterative right shifter
package shift_right_iter_pkg;

  // Default operand/result width of the core datapath.
  localparam int WORD_DEFAULT = 32;

  // Shifter state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Opcode fields that control decodes to drive arith_i.
  localparam logic [6:0] OPCODE_OP      = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM  = 7'b0010011;
  localparam logic [2:0] FUNCT3_SR      = 3'b101;
  localparam logic [6:0] FUNCT7_SRL     = 7'b0000000;
  localparam logic [6:0] FUNCT7_SRA     = 7'b0100000;

  // Arithmetic (sign-fill) shift is selected by the SRA funct7 pattern.
  function automatic logic arith_from_funct7(input logic [6:0] funct7);
    return funct7 == FUNCT7_SRA;
  endfunction

endpackage

// File: rtl/shift_right_iter_step.sv
// rtl/shift_right_iter_step.sv - combinational one-bit right step with fill input
module shiftR_step #(
  parameter int WORD = 32
) (
  input  logic [WORD-1:0] data_i,
  input  logic            fill_i,
  output logic [WORD-1:0] data_o
);

  // Drop the LSB and insert the fill bit at the MSB.
  assign data_o = {fill_i, data_i[WORD-1:1]};

endmodule

// File: rtl/shift_right_iter.sv
// rtl/shift_right_iter.sv - iterative one-bit-per-clock SRL/SRA unit (optional SHIFTR_ARITH_EN)
module shift_right_iter
  import shift_right_iter_pkg::*;
#(
  parameter int WORD = WORD_DEFAULT,
  parameter int SHW  = $clog2(WORD)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [WORD-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic            arith_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [WORD-1:0] res_o
);

  state_t          state_q;
  state_t          state_d;
  logic [WORD-1:0] work_q;
  logic [WORD-1:0] res_q;
  logic [WORD-1:0] stepped;
  logic [SHW-1:0]  cnt_q;
  logic            fill_bit;
  logic            accept;
  logic            last_step;

  // A start only counts when the unit is idle; later pulses are dropped.
  assign accept    = (state_q == IDLE) && start_i;
  assign last_step = (state_q == SHIFT) && (cnt_q == SHW'(1));

`ifdef SHIFTR_ARITH_EN
  logic arith_q;

  // Fill mode is latched with the operand so mid-operation changes have no effect.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      arith_q <= 1'b0;
    end else if (accept) begin
      arith_q <= arith_i;
    end
  end

  assign fill_bit = arith_q & work_q[WORD-1];
`else
  logic unused_arith;
  assign unused_arith = arith_i;
  assign fill_bit     = 1'b0;
`endif

  shiftR_step #(
    .WORD (WORD)
  ) u_step (
    .data_i (work_q),
    .fill_i (fill_bit),
    .data_o (stepped)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: zero shift goes straight to DONE, otherwise iterate until the count runs out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (shamt_i == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working register and counter: load on accept, step once per SHIFT cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      work_q <= data_i;
      cnt_q  <= shamt_i;
    end else if (state_q == SHIFT) begin
      work_q <= stepped;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  // Result register only updates on entry to DONE, so it holds through the next operation.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      res_q <= '0;
    end else if (accept && (shamt_i == '0)) begin
      res_q <= data_i;
    end else if (last_step) begin
      res_q <= stepped;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign res_o  = res_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// tb/tb_shift_right_iter.sv - randomized self-checking bench for shift_right_iter
module tb_shift_right_iter;

  localparam int WORD = 32;
  localparam int SHW  = 5;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic            start_i;
  logic [WORD-1:0] data_i;
  logic [SHW-1:0]  shamt_i;
  logic            arith_i;
  logic            busy_o;
  logic            done_o;
  logic [WORD-1:0] res_o;

  int errors = 0;
  int checks = 0;
  logic [WORD-1:0] last_res = '0;

  always #5 clk = ~clk;

  shift_right_iter #(
    .WORD (WORD),
    .SHW  (SHW)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .res_o   (res_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD-1:0] model(input logic [WORD-1:0] d, input int s, input logic a);
    logic sign_fill;
`ifdef SHIFTR_ARITH_EN
    sign_fill = a;
`else
    sign_fill = 1'b0;
`endif
    if (sign_fill) return WORD'($signed(d) >>> s);
    return d >> s;
  endfunction

  task automatic run_op(input logic [WORD-1:0] d, input int s, input logic a, input int inject_at);
    logic [WORD-1:0] exp;
    int done_cyc;
    exp      = model(d, s, a);
    done_cyc = -1;
    @(negedge clk);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = SHW'(s);
    arith_i = a;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    data_i  = $urandom;
    shamt_i = SHW'($urandom);
    arith_i = 1'($urandom);
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      check("busy_high", busy_o, 1);
      if (done_o === 1'b1) begin
        done_cyc = k;
      end else begin
        check("res_hold", res_o, last_res);
        if (k == inject_at) begin
          start_i = 1'b1;
          data_i  = $urandom;
          shamt_i = SHW'($urandom);
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check("done_latency", done_cyc, s + 1);
    check("result", res_o, exp);
    last_res = exp;
    @(negedge clk);
    check("busy_fall", busy_o, 0);
    check("done_single", done_o, 0);
    check("res_after", res_o, exp);
  endtask

  task automatic run_reset(input logic [WORD-1:0] d, input int s, input int abort_at);
    @(negedge clk);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = SHW'(s);
    arith_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 1; k <= abort_at; k++) begin
      @(negedge clk);
    end
    rstn_i = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_res", res_o, 0);
    rstn_i   = 1'b1;
    last_res = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("abort_no_done", done_o, 0);
    end
  endtask

  initial begin
    rstn_i  = 1'b0;
    start_i = 1'b0;
    data_i  = '0;
    shamt_i = '0;
    arith_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_res", res_o, 0);
    rstn_i = 1'b1;

    run_op(32'h8000_0000, 4, 1'b1, 0);
    run_op(32'h8000_0000, 4, 1'b0, 0);
    run_op(32'h1234_5678, 0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 31, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 31, 1'b1, 0);
    run_op(32'h0000_00F0, 8, 1'b0, 3);
    run_reset(32'h0000_00F0, 8, 3);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, int'($urandom_range(0, WORD - 1)), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
